// File: rtl/modexp_controller_if.sv
// Request/response bus between the modexp sequencer and the shared Montgomery multiplier.
interface modexp_controller_if #(
  parameter int unsigned RSA_BITS = 1024
) ();
  logic                mont_start;
  logic [RSA_BITS-1:0] mont_a;
  logic [RSA_BITS-1:0] mont_b;
  logic [RSA_BITS-1:0] mont_m;
  logic [RSA_BITS-1:0] mont_result;
  logic                mont_done;

  modport master (
    output mont_start, mont_a, mont_b, mont_m,
    input  mont_result, mont_done
  );

  modport slave (
    input  mont_start, mont_a, mont_b, mont_m,
    output mont_result, mont_done
  );
endinterface

// File: rtl/modexp_controller.sv
// Left-to-right square-and-multiply sequencer computing X^E mod M on one shared
// Montgomery multiplier; a final multiply by 1 leaves the Montgomery domain.
module modexp_controller #(
  parameter int unsigned RSA_BITS = 1024,
  parameter int unsigned IDX_BITS = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [RSA_BITS-1:0] in_x,
  input  logic [RSA_BITS-1:0] in_r,
  input  logic [RSA_BITS-1:0] in_e,
  input  logic [IDX_BITS-1:0] in_e_len,
  input  logic [RSA_BITS-1:0] in_m,
  modexp_controller_if.master mont,
  output logic [RSA_BITS-1:0] result,
  output logic                done,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE,
    SQR_START,
    SQR_WAIT,
    MUL_START,
    MUL_WAIT,
    CONV_START,
    CONV_WAIT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [RSA_BITS-1:0] a_q, a_d;
  logic [RSA_BITS-1:0] x_q, x_d;
  logic [RSA_BITS-1:0] e_q, e_d;
  logic [RSA_BITS-1:0] m_q, m_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [RSA_BITS-1:0] result_q, result_d;
  logic [RSA_BITS-1:0] mont_a_q, mont_a_d;
  logic [RSA_BITS-1:0] mont_b_q, mont_b_d;
  logic                mont_start_q, mont_start_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [IDX_BITS-1:0] idx_dec;
  logic                e_bit;

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    x_d          = x_q;
    e_d          = e_q;
    m_d          = m_q;
    idx_d        = idx_q;
    result_d     = result_q;
    mont_a_d     = mont_a_q;
    mont_b_d     = mont_b_q;
    mont_start_d = 1'b0;
    done_d       = 1'b0;
    busy_d       = 1'b0;
    idx_dec      = idx_q - IDX_BITS'(1);
    e_bit        = |(e_q & (RSA_BITS'(1) << idx_dec));

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = in_x;
          e_d     = in_e;
          m_d     = in_m;
          a_d     = in_r;
          idx_d   = in_e_len;
          state_d = (in_e_len != '0) ? SQR_START : CONV_START;
        end
      end
      SQR_START: state_d = SQR_WAIT;
      SQR_WAIT: begin
        if (mont.mont_done) begin
          a_d = mont.mont_result;
          if (e_bit) begin
            state_d = MUL_START;
          end else begin
            idx_d   = idx_dec;
            state_d = (idx_dec != '0) ? SQR_START : CONV_START;
          end
        end
      end
      MUL_START: state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mont.mont_done) begin
          a_d     = mont.mont_result;
          idx_d   = idx_dec;
          state_d = (idx_dec != '0) ? SQR_START : CONV_START;
        end
      end
      CONV_START: state_d = CONV_WAIT;
      CONV_WAIT: begin
        if (mont.mont_done) begin
          result_d = mont.mont_result;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Operands are loaded on entry to a START state and held through its WAIT.
    case (state_d)
      SQR_START: begin
        mont_start_d = 1'b1;
        mont_a_d     = a_d;
        mont_b_d     = a_d;
      end
      MUL_START: begin
        mont_start_d = 1'b1;
        mont_a_d     = a_d;
        mont_b_d     = x_d;
      end
      CONV_START: begin
        mont_start_d = 1'b1;
        mont_a_d     = a_d;
        mont_b_d     = RSA_BITS'(1);
      end
      default: ;
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      x_q          <= '0;
      e_q          <= '0;
      m_q          <= '0;
      idx_q        <= '0;
      result_q     <= '0;
      mont_a_q     <= '0;
      mont_b_q     <= '0;
      mont_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      x_q          <= x_d;
      e_q          <= e_d;
      m_q          <= m_d;
      idx_q        <= idx_d;
      result_q     <= result_d;
      mont_a_q     <= mont_a_d;
      mont_b_q     <= mont_b_d;
      mont_start_q <= mont_start_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign mont.mont_start = mont_start_q;
  assign mont.mont_a     = mont_a_q;
  assign mont.mont_b     = mont_b_q;
  assign mont.mont_m     = m_q;
  assign result          = result_q;
  assign done            = done_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_modexp_controller.sv
// Directed bench for modexp_controller with a behavioural Montgomery multiplier
// (RSA_BITS=16, R=2^16, configurable latency).
module tb_modexp_controller;

  localparam int unsigned RB = 16;
  localparam int unsigned IB = 5;
  localparam logic [RB-1:0] M241 = 16'd241;
  localparam logic [RB-1:0] RMOD = 16'd225;   // 2^16 mod 241
  localparam logic [RB-1:0] X5M  = 16'd161;   // 5*R mod 241
  localparam logic [RB-1:0] X2M  = 16'd209;   // 2*R mod 241

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [RB-1:0] in_x = '0, in_r = '0, in_e = '0, in_m = '0;
  logic [IB-1:0] in_e_len = '0;
  logic [RB-1:0] result;
  logic          done, busy;

  int            checks = 0;
  int            errors = 0;
  int            lat = 1;
  int            ms_count = 0;
  int            cnt = 0;
  logic          model_done = 1'b0;
  logic          inj_done = 1'b0;
  logic [RB-1:0] res_q = '0;

  modexp_controller_if #(.RSA_BITS(RB)) bus ();

  modexp_controller #(.RSA_BITS(RB), .IDX_BITS(IB)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_x(in_x), .in_r(in_r), .in_e(in_e), .in_e_len(in_e_len), .in_m(in_m),
    .mont(bus), .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // a*b*2^-16 mod m, bit-serial REDC
  function automatic logic [RB-1:0] mont_f(input logic [RB-1:0] a, input logic [RB-1:0] b,
                                           input logic [RB-1:0] m);
    logic [RB+1:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      if (a[i]) t = t + 18'(b);
      if (t[0]) t = t + 18'(m);
      t = t >> 1;
    end
    if (t >= 18'(m)) t = t - 18'(m);
    return t[RB-1:0];
  endfunction

  assign bus.mont_done   = model_done | inj_done;
  assign bus.mont_result = res_q;

  // Multiplier model: done pulses lat cycles after the mont_start cycle.
  always @(posedge clk) begin
    if (bus.mont_start === 1'b1) begin
      ms_count   <= ms_count + 1;
      cnt        <= lat - 1;
      res_q      <= mont_f(bus.mont_a, bus.mont_b, bus.mont_m);
      model_done <= (lat == 1);
    end else if (cnt > 0) begin
      cnt        <= cnt - 1;
      model_done <= (cnt == 1);
    end else begin
      model_done <= 1'b0;
    end
  end

  task automatic run_op(input logic [RB-1:0] x, input logic [RB-1:0] r, input logic [RB-1:0] e,
                        input logic [IB-1:0] len, input logic [RB-1:0] m,
                        input int inj_start_rel, input int inj_done_rel, input int max_rel,
                        output int done_rel, output logic [RB-1:0] res, output int nstart,
                        output int first_ms, output int busy_err);
    int ms0;
    done_rel = -1; res = '0; first_ms = -1; busy_err = 0;
    @(negedge clk);
    in_x = x; in_r = r; in_e = e; in_e_len = len; in_m = m; start = 1'b1;
    ms0 = ms_count;
    if (busy !== 1'b0) busy_err++;
    for (int rel = 1; rel <= max_rel && done_rel < 0; rel++) begin
      @(negedge clk);
      start = (rel == inj_start_rel);
      if (rel == inj_start_rel) begin
        in_x = 16'd100; in_e = 16'hFFFF; in_e_len = 5'd16; in_m = 16'd251; in_r = 16'd7;
      end
      inj_done = (rel == inj_done_rel);
      if (bus.mont_start === 1'b1 && first_ms < 0) first_ms = rel;
      if (busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin
        done_rel = rel;
        res = result;
      end
    end
    inj_done = 1'b0;
    nstart = ms_count - ms0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (bus.mont_start !== 1'b0) begin errors++; $display("FAIL reset_mont_start: got %0b expected 0", bus.mont_start); end
    checks++; if (result !== 16'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
    checks++; if (bus.mont_m !== 16'd0 || bus.mont_a !== 16'd0 || bus.mont_b !== 16'd0) begin
      errors++; $display("FAIL reset_operands: got m=%0d a=%0d b=%0d expected 0", bus.mont_m, bus.mont_a, bus.mont_b);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int dr, ns, fm, be;
    logic [RB-1:0] rs;
    lat = 5;
    run_op(X5M, RMOD, 16'd11, 5'd4, M241, -1, -1, 200, dr, rs, ns, fm, be);
    checks++; if (dr !== 49) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 49", dr); end
    checks++; if (rs !== 16'd79) begin errors++; $display("FAIL basic_result: got %0d expected 79", rs); end
    checks++; if (ns !== 8) begin errors++; $display("FAIL basic_mont_starts: got %0d expected 8", ns); end
    checks++; if (fm !== 1) begin errors++; $display("FAIL basic_first_start: got %0d expected 1", fm); end
    checks++; if (be !== 0) begin errors++; $display("FAIL basic_busy_window: got %0d bad cycles expected 0", be); end
    checks++; if (bus.mont_m !== M241) begin errors++; $display("FAIL basic_mont_m: got %0d expected 241", bus.mont_m); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: got done=%0b busy=%0b expected 0 0", done, busy);
    end
    checks++; if (result !== 16'd79) begin errors++; $display("FAIL basic_result_held: got %0d expected 79", result); end
  endtask

  task automatic test_zero_len();
    int dr, ns, fm, be;
    logic [RB-1:0] rs;
    lat = 5;
    run_op(X5M, RMOD, 16'd11, 5'd0, M241, -1, -1, 100, dr, rs, ns, fm, be);
    checks++; if (dr !== 7) begin errors++; $display("FAIL zero_len_done_cycle: got %0d expected 7", dr); end
    checks++; if (rs !== 16'd1) begin errors++; $display("FAIL zero_len_result: got %0d expected 1", rs); end
    checks++; if (ns !== 1) begin errors++; $display("FAIL zero_len_mont_starts: got %0d expected 1", ns); end
  endtask

  task automatic test_long_exp();
    int dr, ns, fm, be;
    logic [RB-1:0] rs;
    lat = 1;
    run_op(X2M, RMOD, 16'h8000, 5'd16, M241, -1, -1, 200, dr, rs, ns, fm, be);
    checks++; if (dr !== 37) begin errors++; $display("FAIL long_exp_done_cycle: got %0d expected 37", dr); end
    checks++; if (rs !== 16'd15) begin errors++; $display("FAIL long_exp_result: got %0d expected 15", rs); end
    checks++; if (ns !== 18) begin errors++; $display("FAIL long_exp_mont_starts: got %0d expected 18", ns); end
  endtask

  task automatic test_ignored_inputs();
    int dr, ns, fm, be, ms0;
    logic [RB-1:0] rs;
    lat = 5;
    @(negedge clk); inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_done_pulse: got busy=%0b expected 0", busy); end
    run_op(X5M, RMOD, 16'd11, 5'd4, M241, 3, 1, 200, dr, rs, ns, fm, be);
    checks++; if (dr !== 49) begin errors++; $display("FAIL disturbed_done_cycle: got %0d expected 49", dr); end
    checks++; if (rs !== 16'd79) begin errors++; $display("FAIL disturbed_result: got %0d expected 79", rs); end
    checks++; if (ns !== 8) begin errors++; $display("FAIL disturbed_mont_starts: got %0d expected 8", ns); end
    // start raised during the DONE cycle must be dropped
    ms0 = ms_count;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_cycle_start_busy: got %0b expected 0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (ms_count !== ms0) begin
      errors++; $display("FAIL done_cycle_start_issued: got %0d starts expected 0", ms_count - ms0);
    end
  endtask

  task automatic test_reset_mid();
    int dr, ns, fm, be, ms0, seen_done, seen_busy;
    logic [RB-1:0] rs;
    lat = 5;
    run_op(X5M, RMOD, 16'd11, 5'd4, M241, -1, -1, 38, dr, rs, ns, fm, be);
    checks++; if (dr !== -1) begin errors++; $display("FAIL reset_mid_early_done: got %0d expected -1", dr); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || bus.mont_start !== 1'b0) begin
      errors++; $display("FAIL reset_mid_outputs: got busy=%0b done=%0b ms=%0b expected 0 0 0", busy, done, bus.mont_start);
    end
    checks++; if (result !== 16'd0) begin errors++; $display("FAIL reset_mid_result: got %0d expected 0", result); end
    ms0 = ms_count; seen_done = 0; seen_busy = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
      if (busy !== 1'b0) seen_busy++;
    end
    checks++; if (seen_done !== 0 || seen_busy !== 0 || ms_count !== ms0) begin
      errors++; $display("FAIL reset_mid_late_done: got done=%0d busy=%0d starts=%0d expected 0 0 0",
                         seen_done, seen_busy, ms_count - ms0);
    end
    run_op(X5M, RMOD, 16'd11, 5'd4, M241, -1, -1, 200, dr, rs, ns, fm, be);
    checks++; if (dr !== 49 || rs !== 16'd79) begin
      errors++; $display("FAIL reset_mid_rerun: got cycle=%0d result=%0d expected 49 79", dr, rs);
    end
  endtask

  task automatic test_back_to_back();
    int dr, ns, fm, be;
    logic [RB-1:0] rs;
    lat = 5;
    run_op(X5M, RMOD, 16'd11, 5'd4, M241, -1, -1, 200, dr, rs, ns, fm, be);
    checks++; if (dr !== 49 || rs !== 16'd79) begin
      errors++; $display("FAIL b2b_first: got cycle=%0d result=%0d expected 49 79", dr, rs);
    end
    run_op(X2M, RMOD, 16'h8000, 5'd16, M241, -1, -1, 300, dr, rs, ns, fm, be);
    checks++; if (dr !== 109) begin errors++; $display("FAIL b2b_second_cycle: got %0d expected 109", dr); end
    checks++; if (rs !== 16'd15) begin errors++; $display("FAIL b2b_second_result: got %0d expected 15", rs); end
    checks++; if (be !== 0) begin errors++; $display("FAIL b2b_second_busy: got %0d bad cycles expected 0", be); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_long_exp();
    test_ignored_inputs();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modexp_controller.md
# modexp_controller

Sequencer that computes a modular exponentiation X^E mod M by driving one shared Montgomery multiplier with a left-to-right square-and-multiply schedule. It sits between the command wrapper and the `montgomery` datapath. It latches operands on `start`, issues one multiplication at a time, and folds each result back into an accumulator. The final multiplication by 1 converts the accumulator out of the Montgomery domain.

## Interface
- `RSA_BITS`, 1024, operand, modulus and exponent width.
- `IDX_BITS`, 11, width of `in_e_len` and the bit-index counter; must satisfy 2^IDX_BITS > RSA_BITS.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `in_x`  in  RSA_BITS  base, already in the Montgomery domain (X·R mod M).
- `in_r`  in  RSA_BITS  R mod M, the Montgomery-domain 1 (R = 2^RSA_BITS).
- `in_e`  in  RSA_BITS  exponent.
- `in_e_len`  in  IDX_BITS  number of exponent bits to scan, from bit in_e_len-1 down to bit 0; 0 ≤ in_e_len ≤ RSA_BITS.
- `in_m`  in  RSA_BITS  modulus (odd).
- `mont_start`  out  1  one-cycle start pulse to the multiplier.
- `mont_a`, `mont_b`, `mont_m`  out  RSA_BITS each  multiplier operands.
- `mont_result`  in  RSA_BITS  multiplier result; valid while `mont_done` is high.
- `mont_done`  in  1  multiplier completion pulse.
- `result`  out  RSA_BITS  X^E mod M in the normal domain; held until the next accepted `start`.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SQR_START, SQR_WAIT, MUL_START, MUL_WAIT, CONV_START, CONV_WAIT, DONE.
- IDLE with `start`=1:
  - Latch x, e, m into internal registers.
  - Set A ← in_r and idx ← in_e_len.
  - Next state is SQR_START if in_e_len ≠ 0, otherwise CONV_START.
- SQR_START:
  - Drive mont_a = mont_b = A and `mont_start`=1.
  - Go to SQR_WAIT.
- SQR_WAIT on `mont_done`:
  - A ← mont_result.
  - If e[idx-1] = 1, go to MUL_START.
  - Otherwise decrement idx, then go to SQR_START if the new idx ≠ 0, else CONV_START.
- MUL_START: drive mont_a = A, mont_b = x, `mont_start`=1; go to MUL_WAIT.
- MUL_WAIT on `mont_done`:
  - A ← mont_result and decrement idx.
  - Go to SQR_START if the new idx ≠ 0, else CONV_START.
- CONV_START: drive mont_a = A, mont_b = 1, `mont_start`=1; go to CONV_WAIT.
- CONV_WAIT on `mont_done`: result ← mont_result; go to DONE.
- DONE: `done`=1 for one cycle; go to IDLE.
- `mont_m` equals the latched m at all times after a start.
- `mont_a` and `mont_b` are stable from the START cycle through the whole WAIT state.
- Multiplication count N = in_e_len + popcount(e[in_e_len-1:0]) + 1.

## Timing
- Reset values: state IDLE; `mont_start`, `done` and `busy` are 0; `result`, A, idx and the latched operands are 0.
- `mont_start` is high exactly in the *_START cycles, never two cycles in a row.
- `mont_done` is ignored outside the *_WAIT states. A pulse arriving in a *_START cycle is also ignored.
- `start` outside IDLE is ignored; operands already latched are unaffected.
- `start` in the DONE cycle is ignored. A `start` in the cycle after DONE is accepted.
- Let the multiplier raise `mont_done` L ≥ 1 cycles after a `mont_start` cycle. With `start` accepted at cycle 0:
  - the first START occurs at cycle 1;
  - each multiplication occupies L+1 cycles;
  - `done` is high at cycle N·(L+1)+1;
  - `busy` is high on cycles 1 through N·(L+1)+1.
- `result` updates on the CONV_WAIT capture edge, so it is valid no later than the `done` cycle.
- `reset` asserted mid-operation:
  - The next cycle is IDLE with all outputs at reset values; no further `mont_start` is issued.
  - A `mont_done` arriving later is ignored.
- in_e_len = 0: only the conversion runs (N=1), and the result equals mont(in_r, 1) = 1.

## Test plan
- The bench uses a behavioural Montgomery model with configurable L, RSA_BITS=16 and R=2^16.
- M=241, X=5 (in_x = 5·R mod 241), E=11, in_e_len=4, L=5 -> result=79; N=8; `done` at cycle 49; exactly 8 `mont_start` pulses.
- Same operands with in_e_len=0, L=5 -> result=1; one `mont_start`; `done` at cycle 7.
- E=0x8000, in_e_len=16, X=2, M=241, L=1 -> result=2^32768 mod 241 matches the reference model; N=18; `done` at cycle 37.
- Pulse `start` with different operands during SQR_WAIT, and pulse `mont_done` during IDLE and SQR_START -> no effect; the result and cycle count match an undisturbed run.
- Assert `reset` for 1 cycle during the third MUL_WAIT, then deliver a late `mont_done` -> state IDLE, `busy`=0, `result`=0, no `done`. A subsequent `start` completes correctly.
- Issue two back-to-back runs with `start` on the cycle after `done` -> both results are correct; the second run's latency is independent of the first.
